// File: rtl/data_mem_ctrl24_pkg.sv
// data_mem_ctrl24_pkg: shared widths and FSM encoding for the data memory controller
package data_mem_ctrl24_pkg;
  localparam int DATA_W = 24;
  localparam int DEF_DATA_AW = 14;
  typedef enum logic [2:0] {LOAD, RUN, DUMP_RD, DUMP_OUT, DONE} state_t;
endpackage

// File: rtl/ram24_sp.sv
// ram24_sp: synchronous 24-bit RAM, one write port, registered read (read-before-write)
module ram24_sp
  import data_mem_ctrl24_pkg::*;
#(
  parameter int AW = DEF_DATA_AW
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     waddr,
  input  logic [AW-1:0]     raddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/data_mem_ctrl24.sv
// data_mem_ctrl24: loader-filled data RAM serving the CPU, then dumping a result window
module data_mem_ctrl24
  import data_mem_ctrl24_pkg::*;
#(
  parameter int DATA_AW   = DEF_DATA_AW,
  parameter int DUMP_BASE = 0,
  parameter int DUMP_LEN  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_we,
  input  logic [DATA_AW-1:0] cpu_addr,
  input  logic [DATA_W-1:0]  cpu_wdata,
  output logic [DATA_W-1:0]  cpu_rdata,
  input  logic               cpu_halt,
  input  logic               ld_valid,
  input  logic               ld_last,
  input  logic [DATA_AW-1:0] ld_addr,
  input  logic [DATA_W-1:0]  ld_data,
  output logic               ld_ready,
  output logic               load_done,
  output logic               tx_valid,
  output logic [DATA_W-1:0]  tx_data,
  input  logic               tx_ready,
  output logic               dump_done
);
  localparam int IW = $clog2(DUMP_LEN + 1);
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic last, we, re, cpu_sel, cpu_sel_q;
  logic [DATA_AW-1:0] waddr, raddr, dump_addr;
  logic [DATA_W-1:0] wdata, rdata, cpu_hold;
  assign last      = idx == IW'(DUMP_LEN - 1);
  assign dump_addr = DATA_AW'(DUMP_BASE) + DATA_AW'(idx);
  assign cpu_sel   = state == LOAD || state == RUN;
  assign we        = (state == LOAD && ld_valid) || (state == RUN && cpu_we);
  assign re        = cpu_sel || state == DUMP_RD;
  assign waddr     = state == LOAD ? ld_addr : cpu_addr;
  assign wdata     = state == LOAD ? ld_data : cpu_wdata;
  assign raddr     = state == DUMP_RD ? dump_addr : cpu_addr;
  assign ld_ready  = state == LOAD;
  assign load_done = state != LOAD;
  assign tx_valid  = state == DUMP_OUT;
  assign dump_done = state == DONE;
  assign tx_data   = tx_valid ? rdata : '0;
  // RAM output follows the CPU only while the previous cycle issued a CPU read; otherwise the captured copy
  assign cpu_rdata = cpu_sel_q ? rdata : cpu_hold;
  ram24_sp #(.AW(DATA_AW)) u_ram (
    .clk(clk), .we(we), .re(re), .waddr(waddr), .raddr(raddr), .wdata(wdata), .rdata(rdata)
  );
  always_comb begin
    state_n = state;
    case (state)
      LOAD:     state_n = ld_valid && ld_last ? RUN : LOAD;
      RUN:      state_n = cpu_halt ? DUMP_RD : RUN;
      DUMP_RD:  state_n = DUMP_OUT;
      DUMP_OUT: state_n = !tx_ready ? DUMP_OUT : last ? DONE : DUMP_RD;
      default:  state_n = DONE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= LOAD;
      idx       <= '0;
      cpu_sel_q <= 1'b0;
      cpu_hold  <= '0;
    end else begin
      state     <= state_n;
      idx       <= state == RUN ? '0 : (state == DUMP_OUT && tx_ready && !last) ? idx + IW'(1) : idx;
      cpu_sel_q <= cpu_sel;
      cpu_hold  <= cpu_sel_q ? rdata : cpu_hold;
    end
  end
endmodule

// File: tb/tb_data_mem_ctrl24.sv
// tb_data_mem_ctrl24: table vectors, random traffic vs. memory model, dump and reset sequences
module tb_data_mem_ctrl24;
  localparam int AW = 6;
  localparam int N  = 64;
  logic clk = 0, rst = 1;
  logic cpu_we = 0, cpu_halt = 0, ld_valid = 0, ld_last = 0, tx_ready = 0;
  logic [AW-1:0] cpu_addr = '0, ld_addr = '0;
  logic [23:0] cpu_wdata = '0, ld_data = '0;
  logic [23:0] a_cpu_rdata, b_cpu_rdata, a_tx_data, b_tx_data;
  logic a_ld_ready, b_ld_ready, a_load_done, b_load_done, a_tx_valid, b_tx_valid, a_dump_done, b_dump_done;

  data_mem_ctrl24 #(.DATA_AW(AW), .DUMP_BASE(0), .DUMP_LEN(3)) dut_a (
    .clk(clk), .rst(rst), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(a_cpu_rdata), .cpu_halt(cpu_halt), .ld_valid(ld_valid), .ld_last(ld_last),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(a_ld_ready), .load_done(a_load_done),
    .tx_valid(a_tx_valid), .tx_data(a_tx_data), .tx_ready(tx_ready), .dump_done(a_dump_done)
  );
  data_mem_ctrl24 #(.DATA_AW(AW), .DUMP_BASE(N - 1), .DUMP_LEN(2)) dut_b (
    .clk(clk), .rst(rst), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(b_cpu_rdata), .cpu_halt(cpu_halt), .ld_valid(ld_valid), .ld_last(ld_last),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(b_ld_ready), .load_done(b_load_done),
    .tx_valid(b_tx_valid), .tx_data(b_tx_data), .tx_ready(tx_ready), .dump_done(b_dump_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [23:0]   wdata;
    logic          lv;
    logic [AW-1:0] la;
    logic [23:0]   ld;
    logic [23:0]   exp;
  } vec_t;
  vec_t tbl[8];

  int checks = 0, errors = 0;
  logic [23:0] mem_m[N];
  bit known[N];
  int phase = 0;
  logic [23:0] last_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] img(input int a);
    return a == 0 ? 24'h000011 : a == 1 ? 24'h000022 : a == 2 ? 24'h000033 : 24'h500000 | 24'(a);
  endfunction

  // model: phase 0 = loading, 1 = running, 2 = dumping; reads return pre-write contents
  task automatic run_cycle;
    logic [23:0] exp;
    bit kn;
    exp = mem_m[cpu_addr];
    kn  = known[cpu_addr];
    if (phase == 0 && ld_valid) begin
      mem_m[ld_addr] = ld_data;
      known[ld_addr] = 1;
      if (ld_last) phase = 1;
    end else if (phase == 1) begin
      if (cpu_we) begin
        mem_m[cpu_addr] = cpu_wdata;
        known[cpu_addr] = 1;
      end
      if (cpu_halt) phase = 2;
    end
    tick;
    if (kn) begin
      chk("a_cpu_rdata", a_cpu_rdata, exp);
      chk("b_cpu_rdata", b_cpu_rdata, exp);
      last_rd = exp;
    end
    chk("a_load_done", a_load_done, phase != 0);
    chk("a_ld_ready", a_ld_ready, phase == 0);
    chk("b_load_done", b_load_done, phase != 0);
  endtask

  task automatic rand_cpu;
    cpu_we    = 1'($urandom);
    cpu_halt  = 1'($urandom);
    cpu_addr  = AW'($urandom);
    cpu_wdata = 24'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int na, nb;
    logic [23:0] qa[3], qb[2];
    tbl[0] = '{1'b1, 6'd5,  24'hABCDEF, 1'b0, 6'd0,  24'h0,      24'h500005};
    tbl[1] = '{1'b0, 6'd5,  24'h0,      1'b1, 6'd5,  24'hDEAD00, 24'hABCDEF};
    tbl[2] = '{1'b0, 6'd5,  24'h0,      1'b0, 6'd0,  24'h0,      24'hABCDEF};
    tbl[3] = '{1'b1, 6'd9,  24'h123456, 1'b0, 6'd0,  24'h0,      24'h500009};
    tbl[4] = '{1'b1, 6'd9,  24'h654321, 1'b0, 6'd0,  24'h0,      24'h123456};
    tbl[5] = '{1'b0, 6'd9,  24'h0,      1'b1, 6'd63, 24'h111111, 24'h654321};
    tbl[6] = '{1'b0, 6'd63, 24'h0,      1'b0, 6'd0,  24'h0,      24'h50003F};
    tbl[7] = '{1'b0, 6'd0,  24'h0,      1'b0, 6'd0,  24'h0,      24'h000011};
    qa = '{24'h000011, 24'h000022, 24'h000033};
    qb = '{24'h50003F, 24'h000011};

    repeat (2) tick;
    chk("rst a_cpu_rdata", a_cpu_rdata, 0);
    chk("rst a_tx_valid", a_tx_valid, 0);
    chk("rst a_tx_data", a_tx_data, 0);
    chk("rst a_dump_done", a_dump_done, 0);
    chk("rst a_load_done", a_load_done, 0);
    chk("rst a_ld_ready", a_ld_ready, 1);
    chk("rst b_ld_ready", b_ld_ready, 1);
    rst = 0;

    // load 3..63 then 0,1,2 with random gaps and random CPU stores/halts that must be ignored
    for (int k = 0; k < N; k++) begin
      repeat ($urandom_range(0, 2)) begin
        ld_valid = 0;
        rand_cpu();
        run_cycle();
      end
      ld_valid = 1;
      ld_addr  = AW'((k + 3) % N);
      ld_data  = img((k + 3) % N);
      ld_last  = k == N - 1;
      rand_cpu();
      run_cycle();
      if (k == N - 2) chk("halt in load", a_tx_valid | a_dump_done | a_load_done, 0);
    end
    chk("load_done after last", a_load_done, 1);
    ld_valid = 0; ld_last = 0; cpu_we = 0; cpu_halt = 0; cpu_addr = 1;
    run_cycle();
    chk("read addr1", a_cpu_rdata, 24'h000022);

    for (int i = 0; i < 8; i++) begin
      cpu_we = tbl[i].we; cpu_addr = tbl[i].addr; cpu_wdata = tbl[i].wdata;
      ld_valid = tbl[i].lv; ld_addr = tbl[i].la; ld_data = tbl[i].ld;
      run_cycle();
      chk("tbl cpu_rdata", a_cpu_rdata, tbl[i].exp);
    end

    for (int i = 0; i < 30; i++) begin
      cpu_we = 1'($urandom); cpu_addr = AW'($urandom_range(3, 62)); cpu_wdata = 24'($urandom);
      ld_valid = 1'($urandom); ld_addr = AW'($urandom); ld_data = 24'($urandom);
      run_cycle();
    end
    ld_valid = 0;

    // halt together with a store that must still land
    cpu_we = 1; cpu_addr = 10; cpu_wdata = 24'h777777; cpu_halt = 1;
    run_cycle();
    cpu_halt = 0; cpu_addr = 1; cpu_wdata = 24'h000BAD; tx_ready = 0;
    chk("dump_rd tx_valid", a_tx_valid, 0);
    tick;
    repeat (4) begin
      chk("stall a_tx_valid", a_tx_valid, 1);
      chk("stall a_tx_data", a_tx_data, 24'h000011);
      chk("stall b_tx_data", b_tx_data, 24'h50003F);
      chk("stall a_cpu_rdata", a_cpu_rdata, last_rd);
      chk("stall a_dump_done", a_dump_done, 0);
      tick;
    end
    na = 0; nb = 0;
    for (int i = 0; i < 40 && !(a_dump_done && b_dump_done); i++) begin
      tx_ready = (i % 3) != 1;
      if (a_tx_valid && tx_ready) begin
        if (na < 3) chk("a_tx_data", a_tx_data, qa[na]);
        na++;
      end
      if (b_tx_valid && tx_ready) begin
        if (nb < 2) chk("b_tx_data", b_tx_data, qb[nb]);
        nb++;
      end
      chk("dump a_cpu_rdata", a_cpu_rdata, last_rd);
      tick;
    end
    chk("a_words", na, 3);
    chk("b_words", nb, 2);
    tx_ready = 1;
    repeat (2) tick;
    chk("a_dump_done", a_dump_done, 1);
    chk("b_dump_done", b_dump_done, 1);
    chk("done a_tx_valid", a_tx_valid, 0);
    chk("done b_tx_valid", b_tx_valid, 0);

    // reload, run, halt and abort with a reset inside DUMP_OUT
    cpu_we = 0;
    rst = 1; #2; rst = 0;
    phase = 0;
    ld_valid = 1; ld_last = 1; ld_addr = 40; ld_data = 24'hCAFE01; cpu_addr = 10;
    run_cycle();
    chk("reread addr10", a_cpu_rdata, 24'h777777);
    ld_valid = 0; ld_last = 0; cpu_addr = 1;
    run_cycle();
    chk("reread addr1", a_cpu_rdata, 24'h000022);
    cpu_halt = 1;
    run_cycle();
    cpu_halt = 0; tx_ready = 0;
    tick;
    chk("pre-abort a_tx_valid", a_tx_valid, 1);
    #3 rst = 1;
    #1;
    chk("abort a_tx_valid", a_tx_valid, 0);
    chk("abort b_tx_valid", b_tx_valid, 0);
    chk("abort a_load_done", a_load_done, 0);
    chk("abort a_ld_ready", a_ld_ready, 1);
    chk("abort a_tx_data", a_tx_data, 0);
    tick;
    rst = 0;
    phase = 0;
    ld_valid = 1; ld_last = 1; ld_addr = 41; ld_data = 24'h000041; cpu_addr = 40;
    run_cycle();
    chk("reread addr40", a_cpu_rdata, 24'hCAFE01);
    ld_valid = 0; ld_last = 0; cpu_addr = 2;
    run_cycle();
    chk("reread addr2", a_cpu_rdata, 24'h000033);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl24.md
DATA_MEM_CTRL24 -- requirements
Module: data_mem_ctrl24

Interface
REQ-001 SHALL have parameter DATA_AW, default 14, data address width in words.
REQ-002 SHALL have parameter DUMP_BASE, default 0, first word address of the result dump.
REQ-003 SHALL have parameter DUMP_LEN, default 10, number of words dumped; legal range 1..2^DATA_AW.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port cpu_we  input  1  CPU store strobe.
REQ-007 SHALL have port cpu_addr  input  DATA_AW  CPU word address.
REQ-008 SHALL have port cpu_wdata  input  24  CPU store data.
REQ-009 SHALL have port cpu_rdata  output  24  CPU load data.
REQ-010 SHALL have port cpu_halt  input  1  CPU halted flag.
REQ-011 SHALL have ports ld_valid, ld_last (input 1), ld_addr (input DATA_AW) and ld_data (input 24); together they form the loader write request, with ld_last marking the final word.
REQ-012 SHALL have port ld_ready  output  1  loader word accepted.
REQ-013 SHALL have port load_done  output  1  image loaded; drives CPU chk_receive_done.
REQ-014 SHALL have port tx_valid  output  1  dump word available.
REQ-015 SHALL have port tx_data  output  24  dump word.
REQ-016 SHALL have port tx_ready  input  1  transmitter accepts dump word.
REQ-017 SHALL have port dump_done  output  1  all DUMP_LEN words sent.

Function
REQ-018 SHALL implement FSM states LOAD, RUN, DUMP_RD, DUMP_OUT, DONE.
REQ-019 In LOAD, SHALL hold ld_ready=1; each cycle with ld_valid=1 writes ld_data to mem[ld_addr]. A write with ld_last=1 moves the FSM to RUN on the next cycle.
REQ-020 In LOAD, SHALL ignore cpu_we and cpu_halt; a loader write has exclusive access to the write port.
REQ-021 SHALL hold load_done=1 in RUN, DUMP_RD, DUMP_OUT and DONE, and 0 in LOAD.
REQ-022 In RUN, SHALL write cpu_wdata to mem[cpu_addr] on every cycle with cpu_we=1; ld_valid is ignored and ld_ready=0.
REQ-023 In LOAD and RUN, SHALL register cpu_rdata = mem[cpu_addr] every clock, unconditionally (1-cycle latency). Read-during-write to the same address returns the old data.
REQ-024 RUN SHALL move to DUMP_RD when a cycle samples cpu_halt=1; cpu_we in that same cycle is still performed.
REQ-025 DUMP_RD SHALL issue a read of mem[(DUMP_BASE+idx) mod 2^DATA_AW] and move to DUMP_OUT; idx resets to 0 on entry from RUN.
REQ-026 DUMP_OUT SHALL assert tx_valid with the read word on tx_data, held stable until a tx_ready=1 cycle.
REQ-027 On a DUMP_OUT handshake: if idx==DUMP_LEN-1, SHALL move to DONE; otherwise SHALL increment idx and move to DUMP_RD. Throughput is one word per 2 cycles maximum.
REQ-028 SHALL perform no memory writes in DUMP_RD, DUMP_OUT or DONE; cpu_rdata SHALL hold its last value in those states.
REQ-029 DONE SHALL assert dump_done=1 and hold tx_valid=0; it is exited only by rst.
REQ-030 All address arithmetic SHALL wrap modulo 2^DATA_AW, and idx SHALL be wide enough to count to DUMP_LEN.

Reset
REQ-031 On rst the block SHALL enter LOAD with idx=0, cpu_rdata=0, tx_data=0, tx_valid=0, dump_done=0 and load_done=0; ld_ready becomes 1 in LOAD.
REQ-032 RAM contents SHALL NOT be cleared by rst.
REQ-033 An rst asserted mid-dump SHALL abort the dump immediately and drop tx_valid asynchronously.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding, the data width (24) and the default DATA_AW.
REQ-035 Storage SHALL be a single sub-module, ram24_sp: a synchronous single-port 24-bit RAM with one write port and a registered read. The address and write-data muxes SHALL live in data_mem_ctrl24.

Verification
REQ-036 Load 3 words (addr 0..2 = 0x000011, 0x000022, 0x000033; last on addr 2) -> load_done=1 on the cycle after the last write; cpu_addr=1 gives cpu_rdata=0x000022 one cycle later.
REQ-037 In RUN, cpu_we at addr 5 with 0xABCDEF, then a read of addr 5 -> 0xABCDEF; ld_valid in RUN changes no memory.
REQ-038 cpu_halt=1 with DUMP_LEN=3, DUMP_BASE=0 and tx_ready stuck low for 4 cycles -> tx_data=0x000011 stable with tx_valid held; then 3 handshakes deliver 0x11, 0x22, 0x33 and dump_done=1.
REQ-039 DUMP_BASE=2^DATA_AW-1 with DUMP_LEN=2 -> dump reads the last address and then address 0 (wrap).
REQ-040 rst pulsed during DUMP_OUT -> tx_valid=0 immediately, state LOAD, load_done=0; RAM contents are preserved on re-read after reload.
REQ-041 cpu_halt=1 and cpu_we=1 in LOAD -> no write and no dump; FSM remains in LOAD.
